// File: rtl/recv_msg.sv
// -----------------------------------------------------------------------------
// recv_msg
//   Receive-side message collector. Takes bytes from the uart_rx AXI-stream
//   output and stores them in an MSG_LEN-entry buffer. A message closes when
//   the buffer fills, when a terminator byte arrives, or when no byte arrives
//   for TIMEOUT_CYCLES cycles. The closed message is held for the consumer,
//   who reads it by index and then releases it with msg_ack.
//
// Ports
//   clk          in   clock, everything on posedge
//   rst_n        in   asynchronous active-low reset
//   axis_tdata   in   received byte
//   axis_tvalid  in   byte valid
//   axis_tready  out  byte can be accepted (high while collecting)
//   rd_index     in   buffer read address
//   rd_data      out  registered read data, one cycle after rd_index
//   msg_len      out  bytes stored in the current message
//   msg_done     out  message closed and readable
//   done_cause   out  01 full, 10 terminator, 11 timeout, 00 while not done
//   msg_ack      in   consumer releases the message (only looked at in DONE)
// -----------------------------------------------------------------------------
module recv_msg #(
  parameter int                MSG_LEN        = 26,
  parameter int                N_BITS         = 8,
  parameter int                TERM_EN        = 1,
  parameter logic [N_BITS-1:0] TERM_CHAR      = 8'h0A,
  parameter int                TIMEOUT_CYCLES = 25_000_000
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic [N_BITS-1:0]            axis_tdata,
  input  logic                         axis_tvalid,
  output logic                         axis_tready,
  input  logic [$clog2(MSG_LEN)-1:0]   rd_index,
  output logic [N_BITS-1:0]            rd_data,
  output logic [$clog2(MSG_LEN+1)-1:0] msg_len,
  output logic                         msg_done,
  output logic [1:0]                   done_cause,
  input  logic                         msg_ack
);

  localparam int AW = $clog2(MSG_LEN);
  localparam int LW = $clog2(MSG_LEN + 1);
  localparam int IW = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;

  localparam logic [LW-1:0] LEN_LAST  = LW'(MSG_LEN - 1);
  localparam logic [IW-1:0] IDLE_LAST = IW'(TIMEOUT_CYCLES - 1);

  typedef enum logic { RECV, DONE } state_t;

  typedef enum logic [1:0] {
    CAUSE_NONE    = 2'b00,
    CAUSE_FULL    = 2'b01,
    CAUSE_TERM    = 2'b10,
    CAUSE_TIMEOUT = 2'b11
  } cause_t;

  state_t             state;
  cause_t             cause;
  logic [IW-1:0]      idle_cnt;
  logic [N_BITS-1:0]  mem [MSG_LEN];

  logic accept;
  logic is_term;
  logic store;
  logic close_term;
  logic idle_expired;

  assign axis_tready = (state == RECV);
  assign msg_done    = (state == DONE);
  assign done_cause  = cause;

  assign accept     = axis_tvalid && axis_tready;
  assign is_term    = (TERM_EN != 0) && (axis_tdata == TERM_CHAR);
  // A terminator is never stored; on an empty buffer it is simply dropped.
  assign store      = accept && !is_term;
  assign close_term = accept && is_term && (msg_len != '0);

  // Acceptance is checked before this in the FSM, so a byte landing on the
  // expiry edge wins and restarts the idle count.
  assign idle_expired = (TIMEOUT_CYCLES != 0) && (idle_cnt == IDLE_LAST);

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values of its neighbours.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= RECV;
      msg_len  <= '0;
      idle_cnt <= '0;
      cause    <= CAUSE_NONE;
    end else begin
      case (state)
        RECV: begin
          if (accept) begin
            idle_cnt <= '0;
            if (close_term) begin
              state <= DONE;
              cause <= CAUSE_TERM;
            end else if (store) begin
              msg_len <= msg_len + LW'(1);
              if (msg_len == LEN_LAST) begin
                state <= DONE;
                cause <= CAUSE_FULL;
              end
            end
          end else if ((TIMEOUT_CYCLES != 0) && (msg_len != '0)) begin
            if (idle_expired) begin
              state <= DONE;
              cause <= CAUSE_TIMEOUT;
            end else begin
              idle_cnt <= idle_cnt + IW'(1);
            end
          end
        end
        DONE: begin
          if (msg_ack) begin
            state    <= RECV;
            msg_len  <= '0;
            idle_cnt <= '0;
            cause    <= CAUSE_NONE;
          end
        end
        default: state <= RECV;
      endcase
    end
  end

  // NOTE: the buffer has no reset; stale entries are harmless because only
  // indices below msg_len are meaningful, and leaving it unreset lets it map
  // onto plain RAM.
  always_ff @(posedge clk) begin
    if (store) begin
      mem[msg_len[AW-1:0]] <= axis_tdata;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_data <= '0;
    end else if (int'(rd_index) < MSG_LEN) begin
      rd_data <= mem[rd_index];
    end else begin
      rd_data <= '0;
    end
  end

endmodule

// File: tb/tb_recv_msg.sv
// -----------------------------------------------------------------------------
// tb_recv_msg
//   Directed bench for recv_msg: full close, terminator close, timeout close
//   and its restart, backpressure with ack, asynchronous reset mid-message and
//   out-of-range reads. Inputs change 1 ns after a rising edge and outputs are
//   checked at that same point, well away from the next edge.
// -----------------------------------------------------------------------------
module tb_recv_msg;

  localparam int MSG_LEN = 26;
  localparam int N_BITS  = 8;
  localparam int TMO     = 100;
  localparam int AW      = $clog2(MSG_LEN);
  localparam int LW      = $clog2(MSG_LEN + 1);

  logic              clk = 1'b0;
  logic              rst_n;
  logic [N_BITS-1:0] axis_tdata;
  logic              axis_tvalid;
  logic              axis_tready;
  logic [AW-1:0]     rd_index;
  logic [N_BITS-1:0] rd_data;
  logic [LW-1:0]     msg_len;
  logic              msg_done;
  logic [1:0]        done_cause;
  logic              msg_ack;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  recv_msg #(
    .MSG_LEN       (MSG_LEN),
    .N_BITS        (N_BITS),
    .TERM_EN       (1),
    .TERM_CHAR     (8'h0A),
    .TIMEOUT_CYCLES(TMO)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .axis_tdata (axis_tdata),
    .axis_tvalid(axis_tvalid),
    .axis_tready(axis_tready),
    .rd_index   (rd_index),
    .rd_data    (rd_data),
    .msg_len    (msg_len),
    .msg_done   (msg_done),
    .done_cause (done_cause),
    .msg_ack    (msg_ack)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Advance to 1 ns past the next rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [7:0] b);
    axis_tdata  = b;
    axis_tvalid = 1'b1;
    step();
    axis_tvalid = 1'b0;
  endtask

  task automatic ack();
    msg_ack = 1'b1;
    step();
    msg_ack = 1'b0;
  endtask

  task automatic read_chk(input string tag, input int idx, input logic [7:0] exp);
    rd_index = AW'(idx);
    step();
    check(tag, 32'(rd_data), 32'(exp));
  endtask

  initial begin
    rst_n       = 1'b0;
    axis_tdata  = '0;
    axis_tvalid = 1'b0;
    rd_index    = '0;
    msg_ack     = 1'b0;

    // ---------------- reset values ----------------
    #3;
    check("rst_tready", 32'(axis_tready), 32'd1);
    check("rst_rd_data", 32'(rd_data), 32'd0);
    check("rst_len", 32'(msg_len), 32'd0);
    check("rst_done", 32'(msg_done), 32'd0);
    check("rst_cause", 32'(done_cause), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    step();

    // ---------------- 1. full message ----------------
    for (int i = 0; i < MSG_LEN; i++) begin
      send(8'(8'h41 + i));
      if (i == MSG_LEN - 2) begin
        check("full_len25", 32'(msg_len), 32'd25);
        check("full_not_done25", 32'(msg_done), 32'd0);
      end
    end
    check("full_done", 32'(msg_done), 32'd1);
    check("full_len", 32'(msg_len), 32'd26);
    check("full_cause", 32'(done_cause), 32'b01);
    check("full_tready", 32'(axis_tready), 32'd0);
    for (int i = 0; i < MSG_LEN; i++) begin
      read_chk($sformatf("full_rd%0d", i), i, 8'(8'h41 + i));
    end
    ack();
    check("ack1_done", 32'(msg_done), 32'd0);
    check("ack1_len", 32'(msg_len), 32'd0);
    check("ack1_cause", 32'(done_cause), 32'd0);
    check("ack1_tready", 32'(axis_tready), 32'd1);

    // ---------------- 2. terminator ----------------
    send(8'h0A);
    check("lead_term_done", 32'(msg_done), 32'd0);
    check("lead_term_len", 32'(msg_len), 32'd0);
    send(8'h48);
    send(8'h49);
    send(8'h0A);
    check("term_done", 32'(msg_done), 32'd1);
    check("term_len", 32'(msg_len), 32'd2);
    check("term_cause", 32'(done_cause), 32'b10);
    read_chk("term_rd0", 0, 8'h48);
    read_chk("term_rd1", 1, 8'h49);
    read_chk("term_rd2_stale", 2, 8'h43);

    // ---------------- 4. backpressure and ack ----------------
    rd_index    = '0;
    axis_tdata  = 8'h55;
    axis_tvalid = 1'b1;
    step();
    step();
    step();
    check("bp_tready", 32'(axis_tready), 32'd0);
    check("bp_len", 32'(msg_len), 32'd2);
    check("bp_rd0", 32'(rd_data), 32'h48);
    check("bp_done", 32'(msg_done), 32'd1);
    msg_ack = 1'b1;
    step();
    msg_ack = 1'b0;
    check("bp_ack_done", 32'(msg_done), 32'd0);
    check("bp_ack_len", 32'(msg_len), 32'd0);
    check("bp_ack_tready", 32'(axis_tready), 32'd1);
    step();
    axis_tvalid = 1'b0;
    check("bp_accept_len", 32'(msg_len), 32'd1);
    read_chk("bp_mem0", 0, 8'h55);

    // ---------------- 3. timeout ----------------
    send(8'h31);
    send(8'h32);
    check("tmo_len3", 32'(msg_len), 32'd3);
    for (int k = 1; k < TMO; k++) step();
    check("tmo_not_yet", 32'(msg_done), 32'd0);
    step();
    check("tmo_done", 32'(msg_done), 32'd1);
    check("tmo_len", 32'(msg_len), 32'd3);
    check("tmo_cause", 32'(done_cause), 32'b11);
    read_chk("tmo_rd0", 0, 8'h55);
    read_chk("tmo_rd1", 1, 8'h31);
    read_chk("tmo_rd2", 2, 8'h32);
    ack();

    // Byte on the would-be expiry edge restarts the count.
    send(8'h61);
    send(8'h62);
    send(8'h63);
    for (int k = 1; k < TMO; k++) step();
    check("rst_cnt_not_yet", 32'(msg_done), 32'd0);
    send(8'h64);
    check("rst_cnt_accept_done", 32'(msg_done), 32'd0);
    check("rst_cnt_len", 32'(msg_len), 32'd4);
    for (int k = 1; k < TMO; k++) step();
    check("rst_cnt_not_yet2", 32'(msg_done), 32'd0);
    step();
    check("rst_cnt_done", 32'(msg_done), 32'd1);
    check("rst_cnt_cause", 32'(done_cause), 32'b11);
    check("rst_cnt_len4", 32'(msg_len), 32'd4);
    ack();

    // ---------------- 5. reset mid-message ----------------
    rd_index = '0;
    for (int i = 0; i < 10; i++) send(8'(8'h30 + i));
    check("mid_len10", 32'(msg_len), 32'd10);
    check("mid_rd0", 32'(rd_data), 32'h30);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_len", 32'(msg_len), 32'd0);
    check("async_done", 32'(msg_done), 32'd0);
    check("async_rd_data", 32'(rd_data), 32'd0);
    check("async_tready", 32'(axis_tready), 32'd1);
    @(negedge clk);
    rst_n = 1'b1;
    step();
    for (int i = 0; i < MSG_LEN; i++) send(8'(8'h61 + i));
    check("post_rst_done", 32'(msg_done), 32'd1);
    check("post_rst_len", 32'(msg_len), 32'd26);
    check("post_rst_cause", 32'(done_cause), 32'b01);
    read_chk("post_rst_rd0", 0, 8'h61);
    read_chk("post_rst_rd25", 25, 8'h7A);

    // ---------------- 6. out-of-range read ----------------
    read_chk("oor_rd27", 27, 8'h00);
    read_chk("oor_back_rd1", 1, 8'h62);
    ack();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
